// File: rtl/preg_decode_if.sv
// preg_decode_if: decode/execute stage boundary bundle.
// Carries the decode-side (*D) fields and hazard controls into the
// pipeline register, and the registered execute-side (*E) fields and
// performance counters back out.
//   master : driven by the decode stage / hazard unit
//   slave  : the pipeline register itself
interface preg_decode_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
);
   // Hazard unit controls
   logic                      StallE;
   logic                      FlushE;

   // Decode-side fields
   logic                      ValidD;
   logic                      RegWriteD;
   logic                      MemWriteD;
   logic                      JumpD;
   logic                      BranchD;
   logic                      ALUSrcD;
   logic [1:0]                ResultSrcD;
   logic [2:0]                ALUControlD;
   logic [DATA_WIDTH-1:0]     RD1D;
   logic [DATA_WIDTH-1:0]     RD2D;
   logic [DATA_WIDTH-1:0]     ImmExtD;
   logic [DATA_WIDTH-1:0]     PCD;
   logic [DATA_WIDTH-1:0]     PCPlus4D;
   logic [REG_ADDR_WIDTH-1:0] Rs1D;
   logic [REG_ADDR_WIDTH-1:0] Rs2D;
   logic [REG_ADDR_WIDTH-1:0] RdD;

   // Execute-side registered fields
   logic                      ValidE;
   logic                      RegWriteE;
   logic                      MemWriteE;
   logic                      JumpE;
   logic                      BranchE;
   logic                      ALUSrcE;
   logic [1:0]                ResultSrcE;
   logic [2:0]                ALUControlE;
   logic [DATA_WIDTH-1:0]     RD1E;
   logic [DATA_WIDTH-1:0]     RD2E;
   logic [DATA_WIDTH-1:0]     ImmExtE;
   logic [DATA_WIDTH-1:0]     PCE;
   logic [DATA_WIDTH-1:0]     PCPlus4E;
   logic [REG_ADDR_WIDTH-1:0] Rs1E;
   logic [REG_ADDR_WIDTH-1:0] Rs2E;
   logic [REG_ADDR_WIDTH-1:0] RdE;

   // Performance counters
   logic [CNT_WIDTH-1:0]      StallCountE;
   logic [CNT_WIDTH-1:0]      FlushCountE;

   modport master (
      output StallE, FlushE,
      output ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
      output ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
      output Rs1D, Rs2D, RdD,
      input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
      input  ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
      input  Rs1E, Rs2E, RdE,
      input  StallCountE, FlushCountE
   );

   modport slave (
      input  StallE, FlushE,
      input  ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
      input  ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
      input  Rs1D, Rs2D, RdD,
      output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
      output ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
      output Rs1E, Rs2E, RdE,
      output StallCountE, FlushCountE
   );
endinterface

// File: rtl/preg_decode.sv
// preg_decode: decode-to-execute pipeline register.
// Captures the decoded instruction each cycle; holds on stall, loads an
// all-zero bubble on flush (flush beats stall, reset beats both).
// Optional saturating stall/flush cycle counters are built only when the
// macro PREG_DECODE_PERF_EN is defined; otherwise both counters read 0.
module preg_decode #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
) (
   input logic          clk,
   input logic          rst,
   preg_decode_if.slave bus
);

   // One instruction's worth of execute-stage state
   typedef struct packed {
      logic                      valid;
      logic                      reg_write;
      logic                      mem_write;
      logic                      jump;
      logic                      branch;
      logic                      alu_src;
      logic [1:0]                result_src;
      logic [2:0]                alu_control;
      logic [DATA_WIDTH-1:0]     rd1;
      logic [DATA_WIDTH-1:0]     rd2;
      logic [DATA_WIDTH-1:0]     imm_ext;
      logic [DATA_WIDTH-1:0]     pc;
      logic [DATA_WIDTH-1:0]     pc_plus4;
      logic [REG_ADDR_WIDTH-1:0] rs1;
      logic [REG_ADDR_WIDTH-1:0] rs2;
      logic [REG_ADDR_WIDTH-1:0] rd;
   } stage_t;

   stage_t               stage_d;
   stage_t               stage_q;
   logic [CNT_WIDTH-1:0] stall_cnt;
   logic [CNT_WIDTH-1:0] flush_cnt;

   // Gather the decode-side fields into one record
   always_comb begin
      // NOTE: assign a default to the whole record first so no path through this block can infer a latch.
      stage_d             = '0;
      stage_d.valid       = bus.ValidD;
      stage_d.reg_write   = bus.RegWriteD;
      stage_d.mem_write   = bus.MemWriteD;
      stage_d.jump        = bus.JumpD;
      stage_d.branch      = bus.BranchD;
      stage_d.alu_src     = bus.ALUSrcD;
      stage_d.result_src  = bus.ResultSrcD;
      stage_d.alu_control = bus.ALUControlD;
      stage_d.rd1         = bus.RD1D;
      stage_d.rd2         = bus.RD2D;
      stage_d.imm_ext     = bus.ImmExtD;
      stage_d.pc          = bus.PCD;
      stage_d.pc_plus4    = bus.PCPlus4D;
      stage_d.rs1         = bus.Rs1D;
      stage_d.rs2         = bus.Rs2D;
      stage_d.rd          = bus.RdD;
   end

   // Stage register: reset > flush (bubble) > stall (hold) > load
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, avoiding simulation races.
      if (rst) begin
         stage_q <= '0;
      end else if (bus.FlushE) begin
         stage_q <= '0;
      end else if (!bus.StallE) begin
         stage_q <= stage_d;
      end
   end

`ifdef PREG_DECODE_PERF_EN
   // Saturating event counters; cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bus.FlushE && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
         if (bus.StallE && !bus.FlushE && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end
`else
   // Counters not built: both read as zero
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

   assign bus.ValidE      = stage_q.valid;
   assign bus.RegWriteE   = stage_q.reg_write;
   assign bus.MemWriteE   = stage_q.mem_write;
   assign bus.JumpE       = stage_q.jump;
   assign bus.BranchE     = stage_q.branch;
   assign bus.ALUSrcE     = stage_q.alu_src;
   assign bus.ResultSrcE  = stage_q.result_src;
   assign bus.ALUControlE = stage_q.alu_control;
   assign bus.RD1E        = stage_q.rd1;
   assign bus.RD2E        = stage_q.rd2;
   assign bus.ImmExtE     = stage_q.imm_ext;
   assign bus.PCE         = stage_q.pc;
   assign bus.PCPlus4E    = stage_q.pc_plus4;
   assign bus.Rs1E        = stage_q.rs1;
   assign bus.Rs2E        = stage_q.rs2;
   assign bus.RdE         = stage_q.rd;
   assign bus.StallCountE = stall_cnt;
   assign bus.FlushCountE = flush_cnt;

endmodule

// File: doc/preg_decode.md
# preg_decode

Decode-to-execute pipeline register: the stage boundary directly downstream of the fetch/decode register. Each cycle it captures decoded control signals, register-file read data, immediate, PC values and register indices from the decode stage and presents them to the execute stage. It supports a stall (hold) and a flush (bubble insertion) from the hazard unit, and tracks a valid bit so execute and the hazard unit can tell real instructions from bubbles. Optional saturating performance counters record stall and flush cycles.

## Interface
- DATA_WIDTH, 32, width of data, PC and immediate paths
- REG_ADDR_WIDTH, 5, width of register indices
- CNT_WIDTH, 32, width of performance counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- StallE  in  1  hold current contents
- FlushE  in  1  load a bubble (NOP)
- ValidD  in  1  decode-stage instruction is real
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decoded controls
- ResultSrcD  in  2  result mux select
- ALUControlD  in  3  ALU operation
- RD1D, RD2D  in  DATA_WIDTH  register-file read data
- ImmExtD  in  DATA_WIDTH  sign-extended immediate
- PCD, PCPlus4D  in  DATA_WIDTH  instruction PC and PC+4
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH  register indices
- *E outputs (ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE)  out  same width as matching *D  registered copies
- StallCountE  out  CNT_WIDTH  stall-cycle counter
- FlushCountE  out  CNT_WIDTH  flush-cycle counter

## Operation
- Priority per rising edge: rst > FlushE > StallE > load.
- rst: every output, including ValidE and both counters, becomes 0.
- FlushE=1: all *E fields become 0 (ValidE=0, RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0, RdE=0). This is a NOP that writes nothing and cannot branch. Applies even when StallE=1.
- StallE=1, FlushE=0: all *E fields hold their previous values, including ValidE.
- Otherwise (load): every *E field takes its *D input. ValidE takes ValidD.
- A bubble entering from decode (ValidD=0) loads with ValidE=0. Control fields are still copied verbatim. Execute must qualify side effects with ValidE.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N and stay stable until edge N+1.
- Stall of k cycles holds outputs for k additional edges. Contents loaded before the stall are never lost.
- Flush takes effect at the next edge. A flush asserted during reset is ignored (reset wins).
- Deasserting rst: the first non-reset edge loads or flushes normally. Outputs stay 0 until then.
- Counters update on the same edge as the event they count.

## Configuration
- PREG_DECODE_PERF_EN defined:
  - StallCountE increments on each edge with StallE=1, FlushE=0, rst=0.
  - FlushCountE increments on each edge with FlushE=1, rst=0.
  - Both counters saturate at all-ones and never wrap.
  - Both counters clear only on rst.
- PREG_DECODE_PERF_EN undefined: counter logic is not built. StallCountE and FlushCountE are tied to 0. All other behaviour is identical.

## Test plan
- Reset: drive all *D inputs to nonzero, rst=1 for 2 edges -> every output 0, ValidE=0, counters 0.
- Load: ValidD=1, RD1D=0x12345678, ImmExtD=0xFFFFFFF0, PCD=0x100, RdD=5, RegWriteD=1 -> after one edge those exact values appear on the *E outputs, ValidE=1.
- Stall: load PCD=0x200, then StallE=1 for 3 edges while PCD changes to 0x204/0x208 -> PCE remains 0x200 throughout, StallCountE=3 (perf build).
- Flush over stall: with valid contents held, StallE=1 and FlushE=1 on the same edge -> all outputs 0, ValidE=0, FlushCountE increments by 1 and StallCountE is unchanged.
- Bubble pass-through: ValidD=0 with RegWriteD=1, RdD=7 -> ValidE=0, RegWriteE=1, RdE=7.
- Saturation (perf build, CNT_WIDTH=4): hold StallE=1 for 20 edges -> StallCountE reaches 15 and stays 15; a subsequent rst sets it to 0.
